// File: rtl/arm_pkg.sv
// Shared definitions for the ARM-subset pipeline: ALU command encodings and
// NZCV status layout.
package arm_pkg;

    localparam int unsigned STATUS_W = 4;

    localparam int unsigned N_BIT = 3;
    localparam int unsigned Z_BIT = 2;
    localparam int unsigned C_BIT = 1;
    localparam int unsigned V_BIT = 0;

    localparam logic [3:0] CMD_NOP = 4'b0000;
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    // Undefined encodings act as NOP, so they must not touch the flags either.
    function automatic logic cmd_sets_flags(input logic [3:0] cmd);
        return (cmd != CMD_NOP) && (cmd <= CMD_MVN);
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EX-side inputs and EX/MEM-side outputs of the execute stage.
interface exe_stage_if;
    import arm_pkg::*;

    logic                stall;
    logic                in_valid;
    logic [3:0]          exe_cmd;
    logic [31:0]         val1;
    logic [31:0]         val2;
    logic [31:0]         st_val;
    logic [31:0]         pc;
    logic [23:0]         signed_imm_24;
    logic                s;
    logic                b;
    logic                wb_en;
    logic                mem_r_en;
    logic                mem_w_en;
    logic [3:0]          dest;

    logic [STATUS_W-1:0] status;
    logic                branch_taken;
    logic [31:0]         branch_addr;
    logic                out_valid;
    logic                wb_en_out;
    logic                mem_r_en_out;
    logic                mem_w_en_out;
    logic [31:0]         alu_res;
    logic [31:0]         st_val_out;
    logic [3:0]          dest_out;

    modport master (
        output stall, in_valid, exe_cmd, val1, val2, st_val, pc, signed_imm_24,
               s, b, wb_en, mem_r_en, mem_w_en, dest,
        input  status, branch_taken, branch_addr, out_valid, wb_en_out,
               mem_r_en_out, mem_w_en_out, alu_res, st_val_out, dest_out
    );

    modport slave (
        input  stall, in_valid, exe_cmd, val1, val2, st_val, pc, signed_imm_24,
               s, b, wb_en, mem_r_en, mem_w_en, dest,
        output status, branch_taken, branch_addr, out_valid, wb_en_out,
               mem_r_en_out, mem_w_en_out, alu_res, st_val_out, dest_out
    );

endinterface

// File: rtl/exe_alu.sv
// Combinational ALU: 33-bit add/sub datapath plus logic ops, producing the
// result and candidate NZCV. cv_en says whether C and V are meaningful.
module exe_alu
    import arm_pkg::*;
(
    input  logic [3:0]          cmd,
    input  logic [31:0]         val1,
    input  logic [31:0]         val2,
    input  logic                c_in,
    output logic [31:0]         res,
    output logic [STATUS_W-1:0] nzcv,
    output logic                cv_en
);

    logic [31:0] op_b;
    logic        carry_in;
    logic [32:0] sum;

    // Subtraction reuses the adder: val1 + ~val2 + carry, so C is NOT borrow.
    always_comb begin
        op_b     = val2;
        carry_in = 1'b0;
        cv_en    = 1'b0;
        case (cmd)
            CMD_ADD: cv_en = 1'b1;
            CMD_ADC: begin carry_in = c_in; cv_en = 1'b1; end
            CMD_SUB: begin op_b = ~val2; carry_in = 1'b1; cv_en = 1'b1; end
            CMD_SBC: begin op_b = ~val2; carry_in = c_in; cv_en = 1'b1; end
            default: ;
        endcase
        sum = {1'b0, val1} + {1'b0, op_b} + {32'b0, carry_in};
    end

    always_comb begin
        res = '0;
        case (cmd)
            CMD_MOV: res = val2;
            CMD_MVN: res = ~val2;
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: res = sum[31:0];
            CMD_AND: res = val1 & val2;
            CMD_ORR: res = val1 | val2;
            CMD_EOR: res = val1 ^ val2;
            default: res = '0;
        endcase
    end

    always_comb begin
        nzcv        = '0;
        nzcv[N_BIT] = res[31];
        nzcv[Z_BIT] = (res == 32'd0);
        nzcv[C_BIT] = sum[32];
        nzcv[V_BIT] = (val1[31] == op_b[31]) && (sum[31] != val1[31]);
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, NZCV status register, branch target adder and the
// EX/MEM pipeline register.
module exe_stage
    import arm_pkg::*;
#(
    parameter logic [STATUS_W-1:0] STATUS_RST = 4'b0000
) (
    input logic        clk,
    input logic        rst_n,
    exe_stage_if.slave ex
);

    logic [STATUS_W-1:0] status_q;
    logic [STATUS_W-1:0] status_d;
    logic                out_valid_q, wb_en_q, mem_r_en_q, mem_w_en_q;
    logic [31:0]         alu_res_q, st_val_q;
    logic [3:0]          dest_q;

    logic [31:0]         alu_out;
    logic [STATUS_W-1:0] alu_nzcv;
    logic                alu_cv_en;
    logic                status_upd;

    exe_alu u_alu (
        .cmd  (ex.exe_cmd),
        .val1 (ex.val1),
        .val2 (ex.val2),
        .c_in (status_q[C_BIT]),
        .res  (alu_out),
        .nzcv (alu_nzcv),
        .cv_en(alu_cv_en)
    );

    // Logic ops and moves leave C and V untouched.
    always_comb begin
        status_d        = status_q;
        status_d[N_BIT] = alu_nzcv[N_BIT];
        status_d[Z_BIT] = alu_nzcv[Z_BIT];
        if (alu_cv_en) begin
            status_d[C_BIT] = alu_nzcv[C_BIT];
            status_d[V_BIT] = alu_nzcv[V_BIT];
        end
    end

    assign status_upd = ex.in_valid && ex.s && cmd_sets_flags(ex.exe_cmd);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status_q    <= STATUS_RST;
            out_valid_q <= 1'b0;
            wb_en_q     <= 1'b0;
            mem_r_en_q  <= 1'b0;
            mem_w_en_q  <= 1'b0;
            alu_res_q   <= '0;
            st_val_q    <= '0;
            dest_q      <= '0;
        end else if (!ex.stall) begin
            if (status_upd) status_q <= status_d;
            out_valid_q <= ex.in_valid;
            wb_en_q     <= ex.wb_en & ex.in_valid;
            mem_r_en_q  <= ex.mem_r_en & ex.in_valid;
            mem_w_en_q  <= ex.mem_w_en & ex.in_valid;
            alu_res_q   <= alu_out;
            st_val_q    <= ex.st_val;
            dest_q      <= ex.dest;
        end
    end

    assign ex.branch_addr  = ex.pc + {{6{ex.signed_imm_24[23]}}, ex.signed_imm_24, 2'b00};
    assign ex.branch_taken = ex.in_valid & ex.b & ~ex.stall;

    assign ex.status       = status_q;
    assign ex.out_valid    = out_valid_q;
    assign ex.wb_en_out    = wb_en_q;
    assign ex.mem_r_en_out = mem_r_en_q;
    assign ex.mem_w_en_out = mem_w_en_q;
    assign ex.alu_res      = alu_res_q;
    assign ex.st_val_out   = st_val_q;
    assign ex.dest_out     = dest_q;

endmodule
